ddr_rd_arbiter: RTL and testbench

DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

---
 rtl/ddr_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter that multiplexes N_REQ burst readers onto one AXI4 read channel,
// with at most one burst outstanding at a time.
module ddr_rd_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*8-1:0]      req_len,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       rd_data,
    output logic [N_REQ-1:0]        rd_valid,
    output logic                    rd_last,
    output logic                    rd_err,
    output logic                    len_err,
    output logic                    m_axi_arid,
    output logic [ADDR_W-1:0]       m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_W-1:0]       m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_cnt;
    logic              arvalid_q;
    logic              rready_q;
    logic              rd_err_q;
    logic              len_err_q;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0]        win_len;

    // First valid requester at or above rr_ptr, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!win_found && req_valid[i] && (i == ((int'(rr_ptr) + k) % N_REQ))) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i == int'(win_idx)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_len  = req_len[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            rd_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        addr_q    <= win_addr;
                        len_q     <= win_len;
                        grant     <= win_idx;
                        arvalid_q <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (m_axi_rvalid) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (m_axi_rresp != 2'b00)
                            rd_err_q <= 1'b1;
                        // Early rlast, or a missing rlast on the final expected beat.
                        if ((m_axi_rlast && beat_cnt != len_q) ||
                            (!m_axi_rlast && beat_cnt == len_q))
                            len_err_q <= 1'b1;
                        if (m_axi_rlast) begin
                            rready_q <= 1'b0;
                            rr_ptr   <= (int'(grant) == N_REQ - 1) ? '0 : grant + IDX_W'(1);
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (!rst && state == IDLE && win_found) ? (N_REQ'(1) << win_idx) : '0;
    assign rd_data       = m_axi_rdata;
    assign rd_valid      = (rready_q && m_axi_rvalid) ? (N_REQ'(1) << grant) : '0;
    assign rd_last       = rready_q & m_axi_rlast;
    assign rd_err        = rd_err_q;
    assign len_err       = len_err_q;
    assign m_axi_arid    = 1'b0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: the bench plays the AXI slave and compares the DUT against
// a burst-level model of round-robin order, latched request fields and error flags.
module tb_ddr_rd_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [127:0] req_addr;
    logic [31:0] req_len;
    logic [3:0]  req_ready;
    logic [31:0] rd_data;
    logic [3:0]  rd_valid;
    logic        rd_last;
    logic        rd_err;
    logic        len_err;
    logic        m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    ddr_rd_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_err(rd_err), .len_err(len_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;
    int rr_model = 0;
    bit len_err_model = 0;
    bit exp_rd_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge; e says whether the beat presented on that edge carries an error.
    task automatic tick(input bit e);
        @(posedge clk);
        exp_rd_err = e;
        #1;
    endtask

    function automatic int model_winner(input logic [3:0] v);
        for (int k = 0; k < 4; k++)
            if (v[(rr_model + k) % 4]) return (rr_model + k) % 4;
        return -1;
    endfunction

    task automatic idle_cycles(input int n);
        req_valid = 4'b0000;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("idle_req_ready", req_ready, 4'b0000);
            chk("idle_arvalid", m_axi_arvalid, 1'b0);
            chk("idle_rd_err", rd_err, exp_rd_err);
            chk("idle_len_err", len_err, len_err_model);
            tick(1'b0);
        end
    endtask

    // One complete burst. delta shifts the beat count away from len+1; err_beat is a 0-based
    // beat index carrying SLVERR (-1 for none). Returns the grant seen on req_ready.
    task automatic run_burst(input logic [3:0] vmask, input int ar_delay, input int delta,
                             input int err_beat, input bit fixed, input logic [31:0] faddr,
                             input logic [7:0] flen, input bit drop, output int og);
        logic [31:0] a [4];
        logic [7:0]  l [4];
        logic [31:0] d;
        int w, nb;
        for (int i = 0; i < 4; i++) begin
            a[i] = fixed ? faddr : ($urandom & 32'hFFFF_FFFC);
            l[i] = fixed ? flen : 8'($urandom_range(0, 7));
        end
        req_addr  = {a[3], a[2], a[1], a[0]};
        req_len   = {l[3], l[2], l[1], l[0]};
        req_valid = vmask;
        w = model_winner(vmask);
        @(negedge clk);
        og = -1;
        for (int i = 3; i >= 0; i--) if (req_ready[i]) og = i;
        chk("req_ready", req_ready, 4'b0001 << w);
        chk("idle_rready", m_axi_rready, 1'b0);
        chk("idle_arvalid", m_axi_arvalid, 1'b0);
        chk("idle_rd_err", rd_err, exp_rd_err);
        chk("idle_len_err", len_err, len_err_model);
        tick(1'b0);
        if (drop) begin
            req_valid = 4'b0000;
            req_addr  = {$urandom, $urandom, $urandom, $urandom};
            req_len   = $urandom;
        end
        // Stray R beat while in ADDR must be swallowed.
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        m_axi_rresp  = 2'b11;
        for (int c = 0; c <= ar_delay; c++) begin
            if (c == ar_delay) m_axi_arready = 1'b1;
            @(negedge clk);
            chk("arvalid", m_axi_arvalid, 1'b1);
            chk("araddr", m_axi_araddr, a[w]);
            chk("arlen", m_axi_arlen, l[w]);
            chk("ar_req_ready", req_ready, 4'b0000);
            chk("ar_rd_valid", rd_valid, 4'b0000);
            chk("ar_rd_last", rd_last, 1'b0);
            chk("ar_rready", m_axi_rready, 1'b0);
            chk("ar_rd_err", rd_err, exp_rd_err);
            if (c == ar_delay) begin
                chk("arburst", m_axi_arburst, 2'b01);
                chk("arsize", m_axi_arsize, 3'd2);
                chk("arid", m_axi_arid, 1'b0);
            end
            tick(1'b0);
        end
        m_axi_arready = 1'b0;
        nb = int'(l[w]) + 1 + delta;
        if (nb < 1) nb = 1;
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
                @(negedge clk);
                chk("gap_rd_valid", rd_valid, 4'b0000);
                chk("gap_rready", m_axi_rready, 1'b1);
                chk("gap_rd_err", rd_err, exp_rd_err);
                tick(1'b0);
            end
            d = $urandom;
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = d;
            m_axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = (b == nb - 1);
            @(negedge clk);
            chk("rd_valid", rd_valid, 4'b0001 << w);
            chk("rd_data", rd_data, d);
            chk("rd_last", rd_last, (b == nb - 1));
            chk("rready", m_axi_rready, 1'b1);
            chk("beat_rd_err", rd_err, exp_rd_err);
            tick(b == err_beat);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        if (nb != int'(l[w]) + 1) len_err_model = 1'b1;
        rr_model = (w + 1) % 4;
    endtask

    int og;
    int seq [5];
    int exp_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        req_valid = 4'b1111;
        req_addr = '0;
        req_len = '0;
        m_axi_arready = 1'b0;
        m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_rd_valid", rd_valid, 4'b0000);
        chk("rst_araddr", m_axi_araddr, 32'h0);
        chk("rst_arlen", m_axi_arlen, 8'h0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 4'b0000;
        idle_cycles(2);

        // Single requester, addr 0x100, len 3, arready after 2 cycles.
        run_burst(4'b0001, 2, 0, -1, 1'b1, 32'h100, 8'd3, 1'b0, og);
        chk("grant_basic", og, 0);
        idle_cycles(2);

        // Reposition pointer to 0, then all four held: 0,1,2,3,0 back-to-back.
        run_burst(4'b1000, 0, 0, -1, 1'b0, 32'h0, 8'd0, 1'b1, og);
        for (int i = 0; i < 5; i++) begin
            run_burst(4'b1111, $urandom_range(0, 2), 0, -1, 1'b0, 32'h0, 8'd0, 1'b0, og);
            seq[i] = og;
        end
        for (int i = 0; i < 5; i++) chk("rr_order", seq[i], exp_seq[i]);

        // Error response on beat 2 of 4 delivers all beats with one rd_err pulse.
        run_burst(4'b0100, 0, 0, 1, 1'b1, 32'h2000, 8'd3, 1'b1, og);
        idle_cycles(2);

        // Randomized clean traffic.
        for (int t = 0; t < 40; t++) begin
            logic [3:0] vm;
            vm = 4'($urandom_range(1, 15));
            run_burst(vm, $urandom_range(0, 3), 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                      1'b0, 32'h0, 8'd0, 1'($urandom_range(0, 1)), og);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(1);

        // len 1 with rlast on the first beat; len_err sticks through clean bursts.
        run_burst(4'b0010, 1, -1, -1, 1'b1, 32'h40, 8'd1, 1'b1, og);
        idle_cycles(1);
        run_burst(4'b0001, 0, 0, -1, 1'b0, 32'h0, 8'd0, 1'b1, og);
        run_burst(4'b1000, 1, 0, -1, 1'b0, 32'h0, 8'd0, 1'b1, og);
        run_burst(4'b0100, 0, 1, -1, 1'b0, 32'h0, 8'd0, 1'b1, og);
        idle_cycles(2);

        // Abort in DATA: leaves the DUT's rr_ptr at 3 before reset.
        run_burst(4'b0100, 0, 0, -1, 1'b0, 32'h0, 8'd0, 1'b1, og);
        req_valid = 4'b1000;
        req_addr  = {32'h3000, 96'h0};
        req_len   = {8'd7, 24'h0};
        @(negedge clk);
        chk("abort_req_ready", req_ready, 4'b1000);
        tick(1'b0);
        req_valid = 4'b0000;
        m_axi_arready = 1'b1;
        @(negedge clk);
        chk("abort_arvalid", m_axi_arvalid, 1'b1);
        tick(1'b0);
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1;
        m_axi_rdata = 32'hA5A5_0001;
        @(negedge clk);
        chk("abort_beat1", rd_valid, 4'b1000);
        tick(1'b0);
        m_axi_rdata = 32'hA5A5_0002;
        #1;
        chk("abort_beat2_pre", rd_valid, 4'b1000);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_arvalid_0", m_axi_arvalid, 1'b0);
        chk("abort_rready_0", m_axi_rready, 1'b0);
        chk("abort_rd_valid_0", rd_valid, 4'b0000);
        chk("abort_len_err_0", len_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_axi_rvalid = 1'b0;
        rr_model = 0;
        len_err_model = 1'b0;
        exp_rd_err = 1'b0;
        run_burst(4'b1100, 0, 0, -1, 1'b0, 32'h0, 8'd0, 1'b1, og);
        chk("post_rst_grant", og, 2);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
